// File: rtl/dict_loader.sv
// dict_loader: boot-time sequencer that reads a packed dictionary image from
// instruction memory and replays it as write pulses into dict1/dict2/dict3.
// Image: one header word (N1 in [3:0], N2 in [9:4], N3 in [18:10]), then
// N1 + N2 + N3 entry words in image order.
// Optional feature: define DICT_LOADER_CHECKSUM_EN to read one trailing word
// that must equal the XOR of the header and every entry word.
// Every memory word takes a request phase (valid held until ready), a write
// phase (valid low, write pulse for entries) and a gap phase.
module dict_loader #(
    parameter int          FIELD1_KEY_WIDTH = 3,
    parameter int          FIELD2_KEY_WIDTH = 5,
    parameter int          FIELD3_KEY_WIDTH = 8,
    parameter int          FIELD1_VAL_WIDTH = 7,
    parameter int          FIELD2_VAL_WIDTH = 10,
    parameter int          FIELD3_VAL_WIDTH = 15,
    parameter logic [31:0] TABLE_BASE       = 32'h0001_0000
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [9:0]                  entries_loaded,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [31:0]                 mem_req_addr,
    input  logic [31:0]                 mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_LOAD1 = 3'd2;
    localparam logic [2:0] ST_LOAD2 = 3'd3;
    localparam logic [2:0] ST_LOAD3 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;
`ifdef DICT_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM  = 3'd7;
    // After the last entry the checksum word still has to be fetched.
    localparam logic [2:0] ST_END   = ST_CSUM;
`else
    localparam logic [2:0] ST_END   = ST_DONE;
`endif

    // Per-word handshake phase.
    localparam logic [1:0] PH_REQ = 2'd0;
    localparam logic [1:0] PH_WR  = 2'd1;
    localparam logic [1:0] PH_GAP = 2'd2;

    localparam logic [31:0] CAP1 = 32'd1 << FIELD1_KEY_WIDTH;
    localparam logic [31:0] CAP2 = 32'd1 << FIELD2_KEY_WIDTH;
    localparam logic [31:0] CAP3 = 32'd1 << FIELD3_KEY_WIDTH;

    logic [2:0]  state;
    logic [1:0]  phase;
    logic [3:0]  rem1;
    logic [5:0]  rem2;
    logic [8:0]  rem3;
`ifdef DICT_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;
`endif

    logic [3:0]  hdr_n1;
    logic [5:0]  hdr_n2;
    logic [8:0]  hdr_n3;
    logic        hdr_bad;
    logic [2:0]  hdr_next;
    logic [2:0]  wr_next;
    logic        load_empty;
    logic        capture;
    logic [9:0]  entries_inc;
    logic        unused_rdata_bits;

    // First nonzero dictionary after 'from' in image order, else the end state.
    function automatic logic [2:0] next_state(input logic [2:0] from,
                                              input logic c1_nz,
                                              input logic c2_nz,
                                              input logic c3_nz);
        if (from == ST_HDR && c1_nz)
            return ST_LOAD1;
        if ((from == ST_HDR || from == ST_LOAD1) && c2_nz)
            return ST_LOAD2;
        if ((from == ST_HDR || from == ST_LOAD1 || from == ST_LOAD2) && c3_nz)
            return ST_LOAD3;
        return ST_END;
    endfunction

    assign hdr_n1  = mem_req_rdata[3:0];
    assign hdr_n2  = mem_req_rdata[9:4];
    assign hdr_n3  = mem_req_rdata[18:10];
    assign hdr_bad = (32'(hdr_n1) > CAP1) || (32'(hdr_n2) > CAP2) || (32'(hdr_n3) > CAP3);
    assign hdr_next = next_state(ST_HDR, hdr_n1 != 4'd0, hdr_n2 != 6'd0, hdr_n3 != 9'd0);
    assign wr_next  = next_state(state, rem1 != 4'd0, rem2 != 6'd0, rem3 != 9'd0);
    assign load_empty = (state == ST_LOAD1 && rem1 == 4'd0) ||
                        (state == ST_LOAD2 && rem2 == 6'd0) ||
                        (state == ST_LOAD3 && rem3 == 9'd0);
    // Ready is only meaningful while a request is outstanding.
    assign capture     = mem_req_valid && mem_req_ready;
    assign entries_inc = (entries_loaded == 10'h3FF) ? entries_loaded : entries_loaded + 10'd1;
    // Header bits [31:19] carry no information.
    assign unused_rdata_bits = ^mem_req_rdata[31:19];

    // Sequencer: state, handshake phase, address, counters and all outputs.
    // NOTE: every output here is a flop, so the memory port and the
    // dictionary write ports see glitch-free signals straight from registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state              <= ST_IDLE;
            phase              <= PH_REQ;
            rem1               <= '0;
            rem2               <= '0;
            rem3               <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            entries_loaded     <= '0;
            mem_req_valid      <= 1'b0;
            mem_req_addr       <= '0;
            dict1_write_enable <= 1'b0;
            dict1_write_val    <= '0;
            dict2_write_enable <= 1'b0;
            dict2_write_val    <= '0;
            dict3_write_enable <= 1'b0;
            dict3_write_val    <= '0;
`ifdef DICT_LOADER_CHECKSUM_EN
            csum_acc           <= '0;
`endif
        end else begin
            // NOTE: write enables default low each cycle and are overridden
            // below only on a capture, which makes them single-cycle pulses.
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_HDR;
                        phase          <= PH_REQ;
                        mem_req_addr   <= TABLE_BASE;
                        mem_req_valid  <= 1'b1;
                        busy           <= 1'b1;
                        entries_loaded <= '0;
`ifdef DICT_LOADER_CHECKSUM_EN
                        csum_acc       <= '0;
`endif
                    end
                end

                ST_DONE, ST_ERR: begin
                    // Terminal: only resetn leaves these states.
                end

                default: begin
                    case (phase)
                        PH_REQ: begin
                            if (capture) begin
                                mem_req_valid <= 1'b0;
                                mem_req_addr  <= mem_req_addr + 32'd4;
                                phase         <= PH_WR;
`ifdef DICT_LOADER_CHECKSUM_EN
                                csum_acc      <= csum_acc ^ mem_req_rdata;
`endif
                                case (state)
                                    ST_HDR: begin
                                        if (hdr_bad) begin
                                            state <= ST_ERR;
                                            error <= 1'b1;
                                            busy  <= 1'b0;
                                        end else begin
                                            rem1  <= hdr_n1;
                                            rem2  <= hdr_n2;
                                            rem3  <= hdr_n3;
                                            state <= hdr_next;
                                            if (hdr_next == ST_DONE) begin
                                                done <= 1'b1;
                                                busy <= 1'b0;
                                            end
                                        end
                                    end
                                    ST_LOAD1: begin
                                        dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                                        dict1_write_enable <= 1'b1;
                                        rem1               <= rem1 - 4'd1;
                                        entries_loaded     <= entries_inc;
                                    end
                                    ST_LOAD2: begin
                                        dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                                        dict2_write_enable <= 1'b1;
                                        rem2               <= rem2 - 6'd1;
                                        entries_loaded     <= entries_inc;
                                    end
                                    ST_LOAD3: begin
                                        dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                                        dict3_write_enable <= 1'b1;
                                        rem3               <= rem3 - 9'd1;
                                        entries_loaded     <= entries_inc;
                                    end
`ifdef DICT_LOADER_CHECKSUM_EN
                                    ST_CSUM: begin
                                        busy <= 1'b0;
                                        if (mem_req_rdata == csum_acc) begin
                                            state <= ST_DONE;
                                            done  <= 1'b1;
                                        end else begin
                                            state <= ST_ERR;
                                            error <= 1'b1;
                                        end
                                    end
`endif
                                    default: begin
                                    end
                                endcase
                            end
                        end

                        PH_WR: begin
                            // The write pulse is on the port this cycle; move on
                            // once the current dictionary has been drained.
                            phase <= PH_GAP;
                            if (load_empty) begin
                                state <= wr_next;
                                if (wr_next == ST_DONE) begin
                                    done <= 1'b1;
                                    busy <= 1'b0;
                                end
                            end
                        end

                        default: begin
                            phase         <= PH_REQ;
                            mem_req_valid <= 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dict_loader.sv
// Self-checking bench for dict_loader: a table of header vectors, randomized
// images checked against a behavioural model of the image format, and
// hand-written sequences for start timing, ready stalls and mid-load reset.
// Follows DICT_LOADER_CHECKSUM_EN when it is defined for the build.
module tb_dict_loader;

    localparam int          KW1  = 3;
    localparam int          KW2  = 5;
    localparam int          KW3  = 8;
    localparam int          W1   = 7;
    localparam int          W2   = 10;
    localparam int          W3   = 15;
    localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef DICT_LOADER_CHECKSUM_EN
    localparam int          CSUM_WORDS = 1;
`else
    localparam int          CSUM_WORDS = 0;
`endif

    typedef struct {
        int          dict;
        logic [31:0] val;
    } wr_t;

    typedef struct {
        logic [31:0] hdr;
        int          dly;
        bit          exp_err;
        int          exp_entries;
    } vec_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [9:0]    entries_loaded;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic [31:0]   mem_req_rdata;
    logic          dict1_write_enable;
    logic [W1-1:0] dict1_write_val;
    logic          dict2_write_enable;
    logic [W2-1:0] dict2_write_val;
    logic          dict3_write_enable;
    logic [W3-1:0] dict3_write_val;

    dict_loader #(
        .FIELD1_KEY_WIDTH(KW1),
        .FIELD2_KEY_WIDTH(KW2),
        .FIELD3_KEY_WIDTH(KW3),
        .FIELD1_VAL_WIDTH(W1),
        .FIELD2_VAL_WIDTH(W2),
        .FIELD3_VAL_WIDTH(W3),
        .TABLE_BASE(BASE)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .busy(busy),
        .done(done),
        .error(error),
        .entries_loaded(entries_loaded),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_req_rdata(mem_req_rdata),
        .dict1_write_enable(dict1_write_enable),
        .dict1_write_val(dict1_write_val),
        .dict2_write_enable(dict2_write_enable),
        .dict2_write_val(dict2_write_val),
        .dict3_write_enable(dict3_write_enable),
        .dict3_write_val(dict3_write_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory image, responder knobs and observed traffic.
    logic [31:0] img [0:1023];
    int          img_len   = 0;
    int          delay_cfg = 0;     // -1: random 0..3 cycles per request
    bit          noise     = 1'b0;  // toggle ready while valid is low
    logic [31:0] got_rd[$];
    wr_t         got_wr[$];
    logic [31:0] preset[$];         // fixed entry words, used before random ones

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] mk_hdr(input int n1, input int n2, input int n3);
        logic [31:0] h;
        h = '0;
        h[3:0]   = 4'(n1);
        h[9:4]   = 6'(n2);
        h[18:10] = 9'(n3);
        return h;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_done"},  done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_entries"}, 32'(entries_loaded), 32'd0);
        check({tag, "_valid"}, mem_req_valid, 1'b0);
        check({tag, "_addr"},  mem_req_addr, 32'd0);
        check({tag, "_we"},    {dict1_write_enable, dict2_write_enable, dict3_write_enable}, 3'b000);
        check({tag, "_vals"},  32'({dict1_write_val, dict2_write_val, dict3_write_val}), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Memory responder and write-port monitor share one process so the
    // "ready was given last cycle" flag is free of ordering races.
    initial begin : mem_and_mon
        bit          new_req;
        bit          gave_ready;
        int          wait_cnt;
        int          cur_delay;
        int          nwe;
        logic [31:0] first_addr;
        logic [31:0] off;
        wr_t         w;
        new_req = 1'b1; gave_ready = 1'b0; wait_cnt = 0; cur_delay = 0; first_addr = '0;
        mem_req_ready = 1'b0;
        mem_req_rdata = '0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                nwe = int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable);
                if (nwe != 0) begin
                    check("one_write_enable", 32'(nwe), 32'd1);
                    check("write_follows_capture", gave_ready, 1'b1);
                    check("busy_during_write", busy, 1'b1);
                    if (dict1_write_enable) begin w.dict = 1; w.val = 32'(dict1_write_val); got_wr.push_back(w); end
                    if (dict2_write_enable) begin w.dict = 2; w.val = 32'(dict2_write_val); got_wr.push_back(w); end
                    if (dict3_write_enable) begin w.dict = 3; w.val = 32'(dict3_write_val); got_wr.push_back(w); end
                end
            end
            gave_ready = 1'b0;
            if (!resetn || !mem_req_valid) begin
                if (resetn && !new_req)
                    check("valid_held_until_ready", mem_req_valid, 1'b1);
                new_req       = 1'b1;
                mem_req_ready = (noise && resetn) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_req_rdata = $urandom;
            end else begin
                if (new_req) begin
                    new_req    = 1'b0;
                    wait_cnt   = 0;
                    first_addr = mem_req_addr;
                    cur_delay  = (delay_cfg >= 0) ? delay_cfg : int'($urandom_range(0, 3));
                end else begin
                    check("addr_stable_while_stalled", mem_req_addr, first_addr);
                end
                if (wait_cnt >= cur_delay) begin
                    off = mem_req_addr - BASE;
                    if (mem_req_addr >= BASE && (off >> 2) < 32'(img_len))
                        mem_req_rdata = img[off >> 2];
                    else
                        mem_req_rdata = 32'hDEAD_BEEF;
                    mem_req_ready = 1'b1;
                    got_rd.push_back(mem_req_addr);
                    gave_ready = 1'b1;
                    new_req    = 1'b1;
                end else begin
                    mem_req_ready = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Builds an image from the header, runs one load and compares everything
    // observable against what the image format dictates.
    task automatic run_image(input logic [31:0] hdr, input int dly, input bit nz,
                             input bit corrupt, output bit got_err, output int got_entries);
        int          n1, n2, n3, total, exp_reads, m;
        bit          bad, exp_done;
        logic [31:0] x;
        wr_t         w;
        wr_t         exp_wr[$];
        n1 = int'(hdr[3:0]);
        n2 = int'(hdr[9:4]);
        n3 = int'(hdr[18:10]);
        bad = (n1 > (1 << KW1)) || (n2 > (1 << KW2)) || (n3 > (1 << KW3));
        total = n1 + n2 + n3;
        do_reset();
        img[0] = hdr;
        x = hdr;
        for (int i = 1; i <= total; i++) begin
            img[i] = (i - 1 < preset.size()) ? preset[i - 1] : $urandom;
            x ^= img[i];
        end
        img[total + 1] = corrupt ? (x ^ 32'h0000_0100) : x;
        img_len = total + 2;

        exp_wr.delete();
        if (!bad) begin
            for (int i = 1; i <= total; i++) begin
                if (i <= n1) begin
                    w.dict = 1; w.val = img[i] & ((32'd1 << W1) - 1);
                end else if (i <= n1 + n2) begin
                    w.dict = 2; w.val = img[i] & ((32'd1 << W2) - 1);
                end else begin
                    w.dict = 3; w.val = img[i] & ((32'd1 << W3) - 1);
                end
                exp_wr.push_back(w);
            end
        end
        exp_reads = bad ? 1 : 1 + total + CSUM_WORDS;
        exp_done  = !bad && !(CSUM_WORDS == 1 && corrupt);

        got_rd.delete();
        got_wr.delete();
        delay_cfg = dly;
        noise     = nz;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cycle1_busy", busy, 1'b1);
        check("cycle1_valid", mem_req_valid, 1'b1);
        check("cycle1_addr", mem_req_addr, BASE);

        for (int c = 0; c < 20000 && !(done || error); c++)
            @(negedge clk);
        check("load_finished", done | error, 1'b1);
        check("busy_low_at_end", busy, 1'b0);
        check("done", done, exp_done);
        check("error", error, !exp_done);
        check("entries_loaded", 32'(entries_loaded), 32'(exp_wr.size()));
        check("read_count", 32'(got_rd.size()), 32'(exp_reads));
        m = (got_rd.size() < exp_reads) ? got_rd.size() : exp_reads;
        for (int i = 0; i < m; i++)
            check("read_addr", got_rd[i], BASE + 32'(4 * i));
        check("write_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        m = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < m; i++) begin
            check("write_dict", 32'(got_wr[i].dict), 32'(exp_wr[i].dict));
            check("write_val", got_wr[i].val, exp_wr[i].val);
        end

        // Terminal states ignore a fresh start.
        noise = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("no_read_after_end", 32'(got_rd.size()), 32'(m == m ? exp_reads : 0));
        check("end_state_sticky", {done, error, busy}, {exp_done, !exp_done, 1'b0});

        got_err     = error;
        got_entries = int'(entries_loaded);
    endtask

    vec_t tbl[9];

    initial begin : main
        bit          e;
        int          n;
        bit          seen2;
        logic [31:0] h;
        bit          corrupt;

        tbl[0] = '{mk_hdr(2, 1, 0),                  1, 1'b0, 3};
        tbl[1] = '{mk_hdr(9, 0, 0),                  0, 1'b1, 0};
        tbl[2] = '{mk_hdr(0, 0, 0),                  0, 1'b0, 0};
        tbl[3] = '{mk_hdr(8, 32, 0),                 0, 1'b0, 40};
        tbl[4] = '{mk_hdr(0, 33, 0),                 1, 1'b1, 0};
        tbl[5] = '{mk_hdr(0, 0, 257),                0, 1'b1, 0};
        tbl[6] = '{mk_hdr(1, 0, 256),                0, 1'b0, 257};
        tbl[7] = '{mk_hdr(1, 2, 3) | 32'hFFF8_0000,  2, 1'b0, 6};
        tbl[8] = '{mk_hdr(0, 0, 5),                 -1, 1'b0, 5};

        // Reset state.
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        resetn = 1'b1;

        // Test-plan image with fixed entry values.
        preset = '{32'h0000_0013, 32'hFFFF_FF33, 32'h0000_00C8};
        run_image(mk_hdr(2, 1, 0), 1, 1'b0, 1'b0, e, n);
        if (got_wr.size() == 3) begin
            check("tp_dict1_first", got_wr[0].val, 32'h13);
            check("tp_dict1_second", got_wr[1].val, 32'h33);
            check("tp_dict2_only", got_wr[2].val, 32'h0C8);
        end else begin
            check("tp_write_count", 32'(got_wr.size()), 32'd3);
        end
        preset.delete();

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            run_image(tbl[i].hdr, tbl[i].dly, 1'b0, 1'b0, e, n);
            check("tbl_error", e, tbl[i].exp_err);
            check("tbl_entries", 32'(n), 32'(tbl[i].exp_entries));
        end

        // Long ready stall on every word.
        run_image(mk_hdr(1, 1, 1), 5, 1'b0, 1'b0, e, n);
        check("stall_entries", 32'(n), 32'd3);

        // Randomized images, delays and stray ready pulses.
        for (int t = 0; t < 12; t++) begin
            h = mk_hdr(int'($urandom_range(0, 9)), int'($urandom_range(0, 34)),
                       int'($urandom_range(0, 40)));
            if ($urandom_range(0, 7) == 0)
                h[18:10] = 9'($urandom_range(257, 511));
            h[31:19] = 13'($urandom);
            corrupt = 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
            corrupt = 1'($urandom_range(0, 1));
`endif
            run_image(h, -1, 1'($urandom_range(0, 1)), corrupt, e, n);
        end

`ifdef DICT_LOADER_CHECKSUM_EN
        run_image(mk_hdr(2, 2, 2), 0, 1'b0, 1'b0, e, n);
        check("csum_good_error", e, 1'b0);
        check("csum_good_done", done, 1'b1);
        run_image(mk_hdr(2, 2, 2), 0, 1'b0, 1'b1, e, n);
        check("csum_bad_error", e, 1'b1);
        check("csum_bad_done", done, 1'b0);
        check("csum_bad_writes", 32'(got_wr.size()), 32'd6);
`endif

        // Asynchronous reset in the middle of dict2.
        do_reset();
        img[0] = mk_hdr(1, 3, 0);
        for (int i = 1; i <= 4; i++) img[i] = $urandom;
        img_len   = 6;
        delay_cfg = 2;
        noise     = 1'b0;
        got_wr.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen2 = 1'b0;
        for (int c = 0; c < 200 && !seen2; c++) begin
            @(negedge clk);
            seen2 = dict2_write_enable;
        end
        check("reached_load2", seen2, 1'b1);
        #2 resetn = 1'b0;
        #1 check_quiet("midload_reset");
        @(negedge clk);
        resetn = 1'b1;
        got_rd.delete();
        repeat (10) @(negedge clk);
        check("idle_after_reset_reads", 32'(got_rd.size()), 32'd0);
        check_quiet("idle_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dict_loader.md
# dict_loader

Boot-time configuration sequencer for the three field dictionaries of the compressed-instruction front end. On `start`, it reads a packed dictionary image from instruction memory and replays it as sequential write pulses into dict1, dict2 and dict3. It holds the fetch controller off with `busy` until every entry is written. It sits between the memory request port (muxed onto it while `busy`) and the `dictN_write_enable`/`dictN_write_val` inputs of the cache controller.

## Interface
Parameters:
- FIELD1_KEY_WIDTH, 3, dict1 capacity is 2^KEY_WIDTH entries
- FIELD2_KEY_WIDTH, 5, dict2 capacity
- FIELD3_KEY_WIDTH, 8, dict3 capacity
- FIELD1_VAL_WIDTH, 7, dict1 entry width
- FIELD2_VAL_WIDTH, 10, dict2 entry width
- FIELD3_VAL_WIDTH, 15, dict3 entry width
- TABLE_BASE, 32'h0001_0000, byte address of the image header (word aligned)

Ports:
- clk  in  1  clock; one clock domain
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; honoured only in IDLE
- busy  out  1  high from the cycle after an accepted start until DONE/ERR
- done  out  1  sticky; all entries written
- error  out  1  sticky; image rejected
- entries_loaded  out  10  count of write pulses issued since start
- mem_req_valid  out  1  read request
- mem_req_ready  in  1  memory has data on mem_req_rdata this cycle
- mem_req_addr  out  32  word-aligned read address
- mem_req_rdata  in  32  read data, valid when mem_req_ready=1
- dict1_write_enable  out  1  one-cycle write pulse to dict1
- dict1_write_val  out  FIELD1_VAL_WIDTH  value for dict1
- dict2_write_enable  out  1  write pulse to dict2
- dict2_write_val  out  FIELD2_VAL_WIDTH  value for dict2
- dict3_write_enable  out  1  write pulse to dict3
- dict3_write_val  out  FIELD3_VAL_WIDTH  value for dict3

## Operation
- Image layout, in words from TABLE_BASE:
  - Header bits [3:0] = N1, [9:4] = N2, [18:10] = N3. Bits [31:19] are ignored.
  - Then N1 dict1 entries, N2 dict2 entries and N3 dict3 entries, one per word.
  - The value sits in the low VAL_WIDTH bits; upper bits are ignored.
- States: IDLE → HDR → LOAD1 → LOAD2 → LOAD3 → (CSUM) → DONE; ERR.
- Transitions:
  - IDLE: `start` → HDR, with the address set to TABLE_BASE.
  - HDR: the header is captured on ready.
    - If N1 > 2^FIELD1_KEY_WIDTH, N2 > 2^FIELD2_KEY_WIDTH or N3 > 2^FIELD3_KEY_WIDTH → ERR, with no dictionary write.
    - Otherwise → the first LOADk with a nonzero count. If all counts are zero → DONE (or CSUM).
  - LOADk: each ready captures one word and issues one dictk write pulse. A per-dictionary remaining counter decrements; when it reaches zero → the next nonzero LOADk, else DONE/CSUM.
  - Address increments by 4 per captured word and is never reset between dictionaries.
  - DONE and ERR are terminal; only resetn leaves them. `start` in any non-IDLE state is ignored.
- Because dictionaries fill by internal append, entries are written strictly in image order and at most one write_enable is high per cycle.
- `entries_loaded` increments with each write pulse and saturates at 1023.

## Timing
- Reset state: IDLE. All outputs are 0, mem_req_addr = 0 and all write_val = 0. Reset takes effect immediately (asynchronous), including mid-load. Partially loaded dictionaries are cleared by their own resetn.
- Start is sampled in cycle 0. In cycle 1, busy=1, mem_req_valid=1 and mem_req_addr=TABLE_BASE.
- Memory handshake:
  - mem_req_valid and mem_req_addr are held stable until mem_req_ready is sampled high; rdata is captured in that cycle.
  - In the next cycle, valid=0 and, in LOADk, dictk_write_enable=1 with the registered value.
  - The next request is asserted one cycle later. This gives a minimum of 3 cycles per word.
  - mem_req_ready while valid=0 is ignored.
- DONE/ERR: done or error rises, and busy falls, in the cycle after the final capture (or final write pulse).

## Configuration
- DICT_LOADER_CHECKSUM_EN defined:
  - After the last entry, one extra word is read (CSUM state) at the next address.
  - It must equal the XOR of the header and all entry words.
  - Match → DONE. Mismatch → ERR, with error=1 and done=0 (writes already issued stand).
- Undefined: no CSUM state, no extra read; the last entry leads directly to DONE.

## Test plan
- Header N1=2, N2=1, N3=0; entries 7'h13, 7'h33, 10'h0C8; ready 1 cycle after valid → reads at base, +4, +8, +12; dict1 pulses 13, 33; dict2 pulse 0C8; done=1; entries_loaded=3.
- Header N1=9 → exactly one read, error=1, done=0, no write pulses, busy=0.
- Header all zero → single read, done=1, no writes; a `start` after done → no new read.
- ready delayed 5 cycles on an entry → valid and addr stable for all 6 cycles, no write pulse until the cycle after ready.
- resetn low during LOAD2 → outputs 0 in the same cycle; after release, IDLE, and no read without `start`.
- DICT_LOADER_CHECKSUM_EN, correct XOR → done=1; corrupted checksum word → error=1, done=0, with all entry pulses still observed.
